// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional prefetch buffer is enabled with IFU_PREFETCH_EN (see instr_fetch_unit).
package ifu_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } ifu_state_t;

    localparam logic [4:0]  OPC_HALT         = 5'b00001;
    localparam int unsigned DEFAULT_RESET_PC = 'h100;
    localparam int unsigned DEFAULT_PC_STEP  = 2;
    localparam int unsigned OPC_WIDTH        = 5;

    // The opcode lives in the top five bits of the instruction word.
    function automatic logic is_halt_opcode(input logic [OPC_WIDTH-1:0] opc);
        return opc == OPC_HALT;
    endfunction

endpackage

// File: rtl/ifu_ir_buffer.sv
// One-entry instruction holding register (valid/data/pc) with load, pop and flush.
// Priority: flush, then load, then pop; data and pc are retained when the entry empties.
module ifu_ir_buffer #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] pc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the sync RAM, presents ir/ir_pc with a valid/ready handshake.
// Define IFU_PREFETCH_EN to add a one-entry prefetch buffer behind ir.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 26,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned           PC_STEP    = DEFAULT_PC_STEP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] ir,
    output logic [ADDR_WIDTH-1:0] ir_pc,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    input  logic                  redir_valid,
    input  logic [ADDR_WIDTH-1:0] redir_pc,
    output logic                  halted
);

    ifu_state_t            state;
    ifu_state_t            state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;

    logic                  handshake;
    logic                  capture;
    logic                  ir_is_halt;
    logic                  ir_load;
    logic [DATA_WIDTH-1:0] ir_load_data;
    logic [ADDR_WIDTH-1:0] ir_load_pc;

    assign handshake  = ir_valid && ir_ready;
    // A redirect in WAIT discards the word coming back from the RAM.
    assign capture    = (state == WAIT) && !redir_valid;
    assign ir_is_halt = is_halt_opcode(ir[DATA_WIDTH-1 -: OPC_WIDTH]);

`ifdef IFU_PREFETCH_EN
    logic                  pf_valid;
    logic [DATA_WIDTH-1:0] pf_data;
    logic [ADDR_WIDTH-1:0] pf_pc;
    logic                  to_ir;
    logic                  to_pf;
    logic                  pf_pop;
    logic                  pf_keep;
    logic                  ir_keep_valid;
    logic [DATA_WIDTH-1:0] ir_keep_data;
    logic                  can_fetch;

    assign to_ir  = capture && !pf_valid && (!ir_valid || handshake);
    assign to_pf  = capture && !to_ir;
    assign pf_pop = handshake && pf_valid;

    assign ir_load      = to_ir || pf_pop;
    assign ir_load_data = pf_pop ? pf_data : mem_rdata;
    assign ir_load_pc   = pf_pop ? pf_pc   : pc;

    // Fetch ahead only when the prefetch slot will be free and the newest word is not HALT.
    always_comb begin
        pf_keep       = pf_valid && !handshake;
        ir_keep_valid = (ir_valid && !handshake) || pf_pop;
        ir_keep_data  = pf_pop ? pf_data : ir;
        can_fetch     = !pf_keep &&
                        !(ir_keep_valid && is_halt_opcode(ir_keep_data[DATA_WIDTH-1 -: OPC_WIDTH]));
    end

    ifu_ir_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pf_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (to_pf),
        .load_data (mem_rdata),
        .load_pc   (pc),
        .pop       (pf_pop),
        .flush     (redir_valid),
        .valid     (pf_valid),
        .data      (pf_data),
        .pc        (pf_pc)
    );
`else
    assign ir_load      = capture;
    assign ir_load_data = mem_rdata;
    assign ir_load_pc   = pc;
`endif

    ifu_ir_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ir_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ir_load),
        .load_data (ir_load_data),
        .load_pc   (ir_load_pc),
        .pop       (handshake),
        .flush     (redir_valid),
        .valid     (ir_valid),
        .data      (ir),
        .pc        (ir_pc)
    );

    always_comb begin
        state_next = state;
        case (state)
            REQ:  state_next = mem_gnt ? WAIT : REQ;
            WAIT: state_next = HOLD;
            HOLD: begin
`ifdef IFU_PREFETCH_EN
                if (handshake && ir_is_halt) begin
                    state_next = HALT;
                end else if (can_fetch) begin
                    state_next = REQ;
                end
`else
                if (handshake) begin
                    state_next = ir_is_halt ? HALT : REQ;
                end
`endif
            end
            HALT:    state_next = HALT;
            default: state_next = REQ;
        endcase
        if (redir_valid) begin
            state_next = REQ;
        end
    end

    always_comb begin
        pc_next = pc;
        if (redir_valid) begin
            pc_next = {redir_pc[ADDR_WIDTH-1:1], 1'b0};
        end else if (capture) begin
            pc_next = pc + ADDR_WIDTH'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Memory strobes are decoded from state and held off while reset is asserted.
    always_comb begin
        mem_addr = '0;
        mem_cs   = 1'b0;
        if (rst_n) begin
            case (state)
                REQ: begin
                    mem_addr = pc;
                    mem_cs   = mem_gnt;
                end
                WAIT: begin
                    mem_addr = pc;
                    mem_cs   = 1'b1;
                end
                default: begin
                    mem_addr = '0;
                    mem_cs   = 1'b0;
                end
            endcase
        end
    end

    assign mem_oe = mem_cs;
    assign mem_we = 1'b0;
    assign halted = (state == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (default build) with a small sync-RAM model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_gnt;
    logic [25:0] mem_addr;
    logic        mem_cs;
    logic        mem_we;
    logic        mem_oe;
    logic [31:0] mem_rdata;
    logic [31:0] ir;
    logic [25:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redir_valid;
    logic [25:0] redir_pc;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_gnt     (mem_gnt),
        .mem_addr    (mem_addr),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_oe      (mem_oe),
        .mem_rdata   (mem_rdata),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [25:0] a);
        case (a)
            26'h100: return 32'h1000_011E;
            26'h102: return 32'h2000_0004;
            26'h104: return 32'h1800_011C;
            26'h106: return 32'h0C00_0003;
            26'h11A: return 32'h0800_0000;
            26'h140: return 32'h3000_0140;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_cs && mem_oe && !mem_we) mem_rdata <= ram_word(mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; mem_gnt = 1'b1; ir_ready = 1'b1;
        redir_valid = 1'b0; redir_pc = '0;
        repeat (2) tick();
        #1;
        check("rst_cs", mem_cs, 0);
        check("rst_oe", mem_oe, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_ir", ir, 0);
        check("rst_ir_pc", ir_pc, 0);
        check("rst_ir_valid", ir_valid, 0);
        check("rst_halted", halted, 0);

        // First fetch: granted REQ, then WAIT, then ir valid.
        rst_n = 1'b1; #1;
        check("req0_addr", mem_addr, 'h100);
        check("req0_cs", mem_cs, 1);
        check("req0_oe", mem_oe, 1);
        tick();
        check("wait0_cs", mem_cs, 1);
        check("wait0_addr", mem_addr, 'h100);
        check("wait0_valid", ir_valid, 0);
        tick();
        check("f0_ir", ir, 'h1000_011E);
        check("f0_ir_pc", ir_pc, 'h100);
        check("f0_valid", ir_valid, 1);
        check("hold0_cs", mem_cs, 0);
        tick();

        // Grant withheld for three cycles.
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("nogrant_cs", mem_cs, 0);
            check("nogrant_oe", mem_oe, 0);
            check("nogrant_addr", mem_addr, 'h102);
            tick();
        end
        mem_gnt = 1'b1; #1;
        check("grant_cs", mem_cs, 1);
        check("grant_addr", mem_addr, 'h102);
        tick();
        tick();
        check("f1_ir", ir, 'h2000_0004);
        check("f1_ir_pc", ir_pc, 'h102);
        tick();
        check("req2_addr", mem_addr, 'h104);
        ir_ready = 1'b0;
        tick();
        tick();

        // Downstream stall: ir stable, no memory traffic.
        for (int i = 0; i < 4; i++) begin
            check("stall_ir", ir, 'h1800_011C);
            check("stall_ir_pc", ir_pc, 'h104);
            check("stall_valid", ir_valid, 1);
            check("stall_cs", mem_cs, 0);
            if (i < 3) tick();
        end
        ir_ready = 1'b1;
        tick();
        check("req3_addr", mem_addr, 'h106);
        check("req3_valid", ir_valid, 0);
        tick();
        check("wait3_cs", mem_cs, 1);

        // Redirect during WAIT discards the capture and aligns the target.
        redir_valid = 1'b1; redir_pc = 'h11B;
        tick();
        redir_valid = 1'b0; #1;
        check("redir_valid_clr", ir_valid, 0);
        check("redir_addr", mem_addr, 'h11A);
        check("redir_cs", mem_cs, 1);
        tick();
        tick();
        check("halt_ir", ir, 'h0800_0000);
        check("halt_ir_pc", ir_pc, 'h11A);
        check("pre_halt", halted, 0);
        tick();
        check("halted", halted, 1);
        check("halted_valid", ir_valid, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("halted_cs", mem_cs, 0);
            check("halted_hold", halted, 1);
        end

        // Leave HALT via redirect.
        redir_valid = 1'b1; redir_pc = 'h100;
        tick();
        redir_valid = 1'b0; #1;
        check("resume_halted", halted, 0);
        check("resume_addr", mem_addr, 'h100);
        check("resume_cs", mem_cs, 1);
        tick();
        tick();
        check("resume_ir", ir, 'h1000_011E);
        tick();
        check("resume_next", mem_addr, 'h102);
        tick();

        // Reset asserted while in WAIT at 'h102.
        check("midrst_wait_cs", mem_cs, 1);
        rst_n = 1'b0;
        tick();
        check("midrst_cs", mem_cs, 0);
        check("midrst_oe", mem_oe, 0);
        check("midrst_valid", ir_valid, 0);
        check("midrst_halted", halted, 0);
        rst_n = 1'b1; #1;
        check("midrst_pc", mem_addr, 'h100);

        // Redirect coinciding with a HALT handshake: no halt.
        redir_valid = 1'b1; redir_pc = 'h11A;
        tick();
        redir_valid = 1'b0; ir_ready = 1'b0; #1;
        check("rh_addr", mem_addr, 'h11A);
        tick();
        tick();
        check("rh_ir", ir, 'h0800_0000);
        check("rh_valid", ir_valid, 1);
        ir_ready = 1'b1; redir_valid = 1'b1; redir_pc = 'h140;
        tick();
        redir_valid = 1'b0; #1;
        check("rh_halted", halted, 0);
        check("rh_valid_clr", ir_valid, 0);
        check("rh_next_addr", mem_addr, 'h140);
        check("rh_next_cs", mem_cs, 1);
        tick();
        tick();
        check("rh_ir2", ir, 'h3000_0140);
        check("rh_ir2_pc", ir_pc, 'h140);
        check("final_we", mem_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
